// File: rtl/rtc_seq_pkg.sv
// rtc_seq_pkg: shared types and constants for the RTC write sequencer.
// Holds the FSM state encoding, the sequence lengths, the RTC register
// address map and a small helper that returns the last table index.
package rtc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } seq_state_t;

    localparam logic       MODE_INIT = 1'b0;
    localparam logic       MODE_SET  = 1'b1;

    localparam logic [3:0] INIT_LEN  = 4'd2;
    localparam logic [3:0] SET_LEN   = 4'd7;

    localparam logic [7:0] ADDR_STAT = 8'h00;
    localparam logic [7:0] ADDR_CTRL = 8'h01;
    localparam logic [7:0] ADDR_SEG  = 8'h21;
    localparam logic [7:0] ADDR_MIN  = 8'h22;
    localparam logic [7:0] ADDR_HORA = 8'h23;
    localparam logic [7:0] ADDR_DIA  = 8'h24;
    localparam logic [7:0] ADDR_MES  = 8'h25;
    localparam logic [7:0] ADDR_ANIO = 8'h26;
    localparam logic [7:0] ADDR_XFER = 8'hF0;

    // Index of the final entry of the selected sequence table.
    function automatic logic [3:0] last_idx(input logic mode);
        logic [3:0] last_s;
        case (mode)
            MODE_INIT: last_s = INIT_LEN - 4'd1;
            MODE_SET:  last_s = SET_LEN - 4'd1;
            default:   last_s = INIT_LEN - 4'd1;
        endcase
        return last_s;
    endfunction

endpackage

// File: rtl/rtc_seq_rom.sv
// rtc_seq_rom: combinational (mode, idx, latched time) -> (addr, data)
// lookup for the write sequences. Out-of-range indices return a harmless
// write of 0x00 to the status register.
module rtc_seq_rom (
    input  logic       mode,
    input  logic [3:0] idx,
    input  logic [7:0] seg,
    input  logic [7:0] min,
    input  logic [7:0] hora,
    input  logic [7:0] dia,
    input  logic [7:0] mes,
    input  logic [7:0] anio,
    output logic [7:0] addr,
    output logic [7:0] data
);
    import rtc_seq_pkg::*;

    // Table lookup for the current sequence entry.
    always_comb begin
        addr = ADDR_STAT;
        data = 8'h00;
        if (mode == MODE_INIT) begin
            case (idx)
                4'd0: begin addr = ADDR_STAT; data = 8'h00; end
                4'd1: begin addr = ADDR_CTRL; data = 8'h00; end
                default: begin addr = ADDR_STAT; data = 8'h00; end
            endcase
        end else begin
            case (idx)
                4'd0: begin addr = ADDR_SEG;  data = seg;   end
                4'd1: begin addr = ADDR_MIN;  data = min;   end
                4'd2: begin addr = ADDR_HORA; data = hora;  end
                4'd3: begin addr = ADDR_DIA;  data = dia;   end
                4'd4: begin addr = ADDR_MES;  data = mes;   end
                4'd5: begin addr = ADDR_ANIO; data = anio;  end
                4'd6: begin addr = ADDR_XFER; data = 8'h00; end
                default: begin addr = ADDR_STAT; data = 8'h00; end
            endcase
        end
    end

endmodule

// File: rtl/rtc_write_sequencer.sv
// rtc_write_sequencer: walks a fixed list of RTC register writes, pulsing
// the write engine's ciclo per entry and driving the AD pads according to
// the engine's Sent_A / Sent_D strobes.
// Build option: define RTC_SEQ_TIMEOUT_EN to add the fin watchdog and the
// err abort path; without it the sequencer waits for fin indefinitely.
module rtc_write_sequencer #(
    parameter int TIMEOUT = 300,
    parameter int TO_W    = 9
) (
    input  logic       Clock_in,
    input  logic       Reset,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] seg,
    input  logic [7:0] min,
    input  logic [7:0] hora,
    input  logic [7:0] dia,
    input  logic [7:0] mes,
    input  logic [7:0] anio,
    input  logic       fin,
    input  logic       sent_a,
    input  logic       sent_d,
    output logic       ciclo,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);
    import rtc_seq_pkg::*;

    seq_state_t state_r;
    seq_state_t state_next_s;
    logic [3:0] idx_r;
    logic [3:0] idx_next_s;
    logic       accept_s;
    logic       mode_r;
    logic [7:0] seg_r, min_r, hora_r, dia_r, mes_r, anio_r;
    logic [7:0] rom_addr_s, rom_data_s;
    logic [7:0] cur_addr_r, cur_data_r;
    logic       ciclo_r, busy_r, done_r;
    logic [7:0] ad_out_r;
    logic       ad_oe_r;

`ifdef RTC_SEQ_TIMEOUT_EN
    localparam logic [TO_W-1:0] WDOG_TERM = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] wdog_r;
    logic            err_r;
`else
    // Sizing parameters only matter when the watchdog is built in.
    logic unused_cfg_s;
    assign unused_cfg_s = (TIMEOUT > TO_W);
`endif

    rtc_seq_rom u_rom (
        .mode (mode_r),
        .idx  (idx_r),
        .seg  (seg_r),
        .min  (min_r),
        .hora (hora_r),
        .dia  (dia_r),
        .mes  (mes_r),
        .anio (anio_r),
        .addr (rom_addr_s),
        .data (rom_data_s)
    );

    // Next-state and index logic of the sequencing FSM.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    idx_next_s   = 4'd0;
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD:  state_next_s = ST_ISSUE;
            ST_ISSUE: state_next_s = ST_WAIT;
            ST_WAIT: begin
                // fin has priority over a simultaneous watchdog expiry
                if (fin) begin
                    if (idx_r == last_idx(mode_r)) begin
                        state_next_s = ST_DONE;
                    end else begin
                        idx_next_s   = idx_r + 4'd1;
                        state_next_s = ST_LOAD;
                    end
                end
`ifdef RTC_SEQ_TIMEOUT_EN
                else if (wdog_r == WDOG_TERM) begin
                    state_next_s = ST_ERR;
                end
`endif
                else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            ST_ERR:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state and table index registers.
    always_ff @(posedge Clock_in or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
            idx_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // Capture mode and time values once, when a start is accepted.
    always_ff @(posedge Clock_in or negedge Reset) begin
        if (!Reset) begin
            mode_r <= 1'b0;
            seg_r  <= 8'h00;
            min_r  <= 8'h00;
            hora_r <= 8'h00;
            dia_r  <= 8'h00;
            mes_r  <= 8'h00;
            anio_r <= 8'h00;
        end else if (accept_s) begin
            mode_r <= mode;
            seg_r  <= seg;
            min_r  <= min;
            hora_r <= hora;
            dia_r  <= dia;
            mes_r  <= mes;
            anio_r <= anio;
        end else begin
            mode_r <= mode_r;
            seg_r  <= seg_r;
            min_r  <= min_r;
            hora_r <= hora_r;
            dia_r  <= dia_r;
            mes_r  <= mes_r;
            anio_r <= anio_r;
        end
    end

    // Register the current write's address/data during LOAD.
    always_ff @(posedge Clock_in or negedge Reset) begin
        if (!Reset) begin
            cur_addr_r <= 8'h00;
            cur_data_r <= 8'h00;
        end else if (state_r == ST_LOAD) begin
            cur_addr_r <= rom_addr_s;
            cur_data_r <= rom_data_s;
        end else begin
            cur_addr_r <= cur_addr_r;
            cur_data_r <= cur_data_r;
        end
    end

`ifdef RTC_SEQ_TIMEOUT_EN
    // Watchdog: cleared on each ciclo, counts cycles spent waiting for fin.
    always_ff @(posedge Clock_in or negedge Reset) begin
        if (!Reset) begin
            wdog_r <= {TO_W{1'b0}};
        end else if (state_r == ST_ISSUE) begin
            wdog_r <= {TO_W{1'b0}};
        end else if (state_r == ST_WAIT) begin
            wdog_r <= wdog_r + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            wdog_r <= wdog_r;
        end
    end

    // err pulse, aligned with the ERR state.
    always_ff @(posedge Clock_in or negedge Reset) begin
        if (!Reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= (state_next_s == ST_ERR);
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    // Control outputs decoded from the next state so they align with it.
    always_ff @(posedge Clock_in or negedge Reset) begin
        if (!Reset) begin
            ciclo_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ciclo_r <= (state_next_s == ST_ISSUE);
            busy_r  <= (state_next_s == ST_LOAD) ||
                       (state_next_s == ST_ISSUE) ||
                       (state_next_s == ST_WAIT);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // AD bus drive, one cycle behind the strobes; address wins on overlap.
    always_ff @(posedge Clock_in or negedge Reset) begin
        if (!Reset) begin
            ad_out_r <= 8'h00;
            ad_oe_r  <= 1'b0;
        end else if (state_r == ST_WAIT) begin
            if (sent_a) begin
                ad_out_r <= cur_addr_r;
                ad_oe_r  <= 1'b1;
            end else if (sent_d) begin
                ad_out_r <= cur_data_r;
                ad_oe_r  <= 1'b1;
            end else begin
                ad_out_r <= 8'h00;
                ad_oe_r  <= 1'b0;
            end
        end else begin
            ad_out_r <= 8'h00;
            ad_oe_r  <= 1'b0;
        end
    end

    assign ciclo  = ciclo_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign ad_out = ad_out_r;
    assign ad_oe  = ad_oe_r;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// tb_rtc_write_sequencer: randomized self-checking bench. A behavioural
// write-engine model answers each ciclo with address/data strobes and fin,
// and checks the AD bus against a queue of expected (addr, data) writes
// built directly from the sequence tables.
`timescale 1ns/1ps
module tb_rtc_write_sequencer;

    logic       Clock_in = 1'b0;
    logic       Reset;
    logic       start;
    logic       mode;
    logic [7:0] seg, min, hora, dia, mes, anio;
    logic       fin, sent_a, sent_d;
    logic       ciclo, ad_oe, busy, done, err;
    logic [7:0] ad_out;

    int n_chk  = 0;
    int n_pass = 0;
    int ciclo_cnt = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int fixed_dly = 0;
    bit nofin     = 1'b0;
    logic [15:0] exp_q[$];
    logic [7:0]  tv[6];

    always #5 Clock_in = ~Clock_in;

    rtc_write_sequencer dut (
        .Clock_in (Clock_in),
        .Reset    (Reset),
        .start    (start),
        .mode     (mode),
        .seg      (seg),
        .min      (min),
        .hora     (hora),
        .dia      (dia),
        .mes      (mes),
        .anio     (anio),
        .fin      (fin),
        .sent_a   (sent_a),
        .sent_d   (sent_d),
        .ciclo    (ciclo),
        .ad_out   (ad_out),
        .ad_oe    (ad_oe),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    endtask

    // Expected write list straight from the sequence tables.
    function automatic void build_exp(input logic m);
        exp_q.delete();
        if (m == 1'b0) begin
            exp_q.push_back({8'h00, 8'h00});
            exp_q.push_back({8'h01, 8'h00});
        end else begin
            for (int i = 0; i < 6; i++) exp_q.push_back({8'h21 + 8'(i), tv[i]});
            exp_q.push_back({8'hF0, 8'h00});
        end
    endfunction

    task automatic drive_times();
        seg = tv[0]; min = tv[1]; hora = tv[2]; dia = tv[3]; mes = tv[4]; anio = tv[5];
    endtask

    // Pulse counters, sampled mid-cycle.
    always @(negedge Clock_in) begin
        if (ciclo) ciclo_cnt <= ciclo_cnt + 1;
        if (done)  done_cnt  <= done_cnt + 1;
        if (err)   err_cnt   <= err_cnt + 1;
    end

    // Engine model for one write: address strobe, gap, data strobe, then fin.
    task automatic eng_write();
        logic [7:0] ea, ed;
        int  dly;
        bit  both;
        int  c;
        if (exp_q.size() == 0) begin
            check_eq("ciclo_expected", 32'd0, 32'd1);
            return;
        end
        {ea, ed} = exp_q.pop_front();
        dly  = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(12, 200));
        both = ($urandom_range(0, 3) == 0);
        c = 0;
        forever begin
            c++;
            sent_a = (c >= 2 && c <= 4);
            sent_d = (c >= 6 && c <= 8) || (both && c >= 2 && c <= 4);
            fin    = (!nofin && c == dly);
            @(posedge Clock_in); #1;
            if (!Reset) begin
                sent_a = 1'b0; sent_d = 1'b0; fin = 1'b0;
                return;
            end
            if (c == 1) check_eq("ciclo_pulse", ciclo, 0);
            if (c == 4) begin
                check_eq(both ? "ad_addr_both" : "ad_addr", ad_out, ea);
                check_eq("ad_oe_addr", ad_oe, 1);
            end
            if (c == 5) check_eq("ad_oe_gap", ad_oe, 0);
            if (c == 8) begin
                check_eq("ad_data", ad_out, ed);
                check_eq("ad_oe_data", ad_oe, 1);
            end
            if (c == 9) begin
                check_eq("ad_oe_idle", ad_oe, 0);
                check_eq("ad_out_idle", ad_out, 0);
            end
            if ((!nofin && c == dly) || (nofin && c > 9 && !busy) || c > 20000) begin
                sent_a = 1'b0; sent_d = 1'b0; fin = 1'b0;
                return;
            end
        end
    endtask

    // Engine process: serve every ciclo seen while out of reset.
    initial begin
        sent_a = 1'b0; sent_d = 1'b0; fin = 1'b0;
        forever begin
            @(posedge Clock_in); #1;
            if (ciclo && Reset) eng_write();
        end
    end

    // Start a sequence and check the 2-cycle start-to-ciclo latency.
    task automatic start_seq(input logic m);
        mode = m;
        drive_times();
        start = 1'b1;
        @(posedge Clock_in); #1;
        start = 1'b0;
        check_eq("accept_busy", busy, 1);
        check_eq("accept_no_ciclo", ciclo, 0);
        @(posedge Clock_in); #1;
        check_eq("first_ciclo", ciclo, 1);
    endtask

    // Full sequence; latch_test also disturbs inputs and restarts while busy.
    task automatic run_seq(input logic m, input bit latch_test);
        int c0, d0, e0, len;
        bit got;
        build_exp(m);
        len = exp_q.size();
        c0 = ciclo_cnt; d0 = done_cnt; e0 = err_cnt;
        start_seq(m);
        if (latch_test) begin
            seg = 8'h59; min = 8'h00; hora = 8'h99;
            repeat (3) @(posedge Clock_in);
            #1 start = 1'b1; mode = ~m;
            @(posedge Clock_in); #1;
            start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(posedge Clock_in); #1;
            if (done) got = 1'b1;
        end
        check_eq("done_seen", got, 1);
        @(posedge Clock_in); #1;
        check_eq("write_count", ciclo_cnt - c0, len);
        check_eq("done_once", done_cnt - d0, 1);
        check_eq("no_err", err_cnt - e0, 0);
        check_eq("busy_after", busy, 0);
        check_eq("done_pulse", done, 0);
        check_eq("writes_left", exp_q.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        int  c0, d0, e0, k;
        bit  got;
        Reset = 1'b0; start = 1'b0; mode = 1'b0;
        tv = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        drive_times();
        repeat (3) @(posedge Clock_in); #1;
        check_eq("rst_ciclo", ciclo, 0);
        check_eq("rst_ad_oe", ad_oe, 0);
        check_eq("rst_ad_out", ad_out, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        Reset = 1'b1;
        @(posedge Clock_in); #1;

        // Init sequence, engine answers 150 cycles after each ciclo.
        fixed_dly = 150;
        run_seq(1'b0, 1'b0);

        // Set-time sequence with the reference values.
        fixed_dly = 0;
        tv = '{8'h45, 8'h30, 8'h12, 8'h15, 8'h04, 8'h16};
        run_seq(1'b1, 1'b0);

        // Inputs change and a second start arrive while busy.
        run_seq(1'b1, 1'b1);

        // Random modes, time values and engine timing.
        for (int it = 0; it < 6; it++) begin
            foreach (tv[i]) tv[i] = 8'($urandom_range(0, 255));
            run_seq(1'($urandom_range(0, 1)), 1'b0);
        end

        // Engine never returns fin.
        nofin = 1'b1;
        foreach (tv[i]) tv[i] = 8'($urandom_range(0, 255));
        build_exp(1'b1);
        d0 = done_cnt; e0 = err_cnt;
        start_seq(1'b1);
`ifdef RTC_SEQ_TIMEOUT_EN
        got = 1'b0; k = 0;
        for (int i = 1; i <= 400 && !got; i++) begin
            @(posedge Clock_in); #1;
            if (err) begin got = 1'b1; k = i; end
        end
        check_eq("err_seen", got, 1);
        check_eq("err_latency_300", (k >= 300 && k <= 301), 1);
        check_eq("err_busy", busy, 0);
        @(posedge Clock_in); #1;
        check_eq("err_pulse", err, 0);
        check_eq("err_once", err_cnt - e0, 1);
        check_eq("err_no_done", done_cnt - d0, 0);
`else
        repeat (400) @(posedge Clock_in);
        #1;
        check_eq("nofin_busy", busy, 1);
        check_eq("nofin_err", err, 0);
        check_eq("nofin_err_cnt", err_cnt - e0, 0);
        check_eq("nofin_no_done", done_cnt - d0, 0);
        @(negedge Clock_in); Reset = 1'b0;
        repeat (2) @(posedge Clock_in);
        @(negedge Clock_in); Reset = 1'b1;
`endif
        nofin = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge Clock_in); #1;

        // Reset during write 3 of a set sequence.
        fixed_dly = 60;
        tv = '{8'h45, 8'h30, 8'h12, 8'h15, 8'h04, 8'h16};
        build_exp(1'b1);
        c0 = ciclo_cnt; d0 = done_cnt; e0 = err_cnt;
        start_seq(1'b1);
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(posedge Clock_in); #1;
            if (ciclo_cnt - c0 >= 3) got = 1'b1;
        end
        check_eq("third_write", got, 1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge Clock_in); #1;
            if (ad_oe) got = 1'b1;
        end
        check_eq("third_write_oe", got, 1);
        @(negedge Clock_in);
        Reset = 1'b0;
        #1;
        check_eq("abort_ciclo", ciclo, 0);
        check_eq("abort_ad_oe", ad_oe, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_ad_out", ad_out, 0);
        repeat (3) @(posedge Clock_in); #1;
        check_eq("abort_no_done", done_cnt - d0, 0);
        check_eq("abort_no_err", err_cnt - e0, 0);
        exp_q.delete();
        @(negedge Clock_in); Reset = 1'b1;
        @(posedge Clock_in); #1;
        fixed_dly = 0;
        run_seq(1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
